// File: rtl/peri_ahb_bridge_pkg.sv
// Shared peripheral-bus definitions: bridge FSM encoding, AHB transfer codes,
// and the geometry of the 8 x 4 KB peripheral window.
package peri_ahb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } bridge_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned PERI_COUNT = 8;
    localparam int unsigned WIN_BYTES  = 4096;
    localparam int unsigned WIN_AW     = $clog2(WIN_BYTES);
    localparam int unsigned PERI_IDX_W = $clog2(PERI_COUNT);
    localparam int unsigned REGION_LSB = WIN_AW + PERI_IDX_W;

    // Peripheral k owns select bit k+1; bit 0 is reserved and never driven.
    function automatic logic [31:0] peri_onehot(input logic [PERI_IDX_W-1:0] idx);
        peri_onehot = 32'h2 << idx;
    endfunction

endpackage

// File: rtl/peri_addr_dec.sv
// Combinational region check and window decode: HADDR -> mapped flag and
// one-hot peripheral select.
module peri_addr_dec
    import peri_ahb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic [31:0] i_haddr,
    output logic        o_mapped,
    output logic [31:0] o_perisel
);

    logic                  w_mapped;
    logic [PERI_IDX_W-1:0] w_idx;
    logic                  w_unused_offset;

    assign w_mapped        = (i_haddr[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB]);
    assign w_idx           = i_haddr[WIN_AW +: PERI_IDX_W];
    assign w_unused_offset = ^i_haddr[WIN_AW-1:0];

    assign o_mapped  = w_mapped;
    assign o_perisel = w_mapped ? peri_onehot(w_idx) : '0;

endmodule

// File: rtl/peri_ahb_bridge.sv
// AHB-Lite slave to simple peripheral bus bridge: SETUP/ACCESS handshake with
// PERIREADY wait states, timeout, and two-cycle AHB error response.
module peri_ahb_bridge
    import peri_ahb_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [31:0] PERISEL,
    output logic [11:0] PERIADDR,
    output logic        PERIWRITE,
    output logic [31:0] PERIWDATA,
    output logic        PERIENABLE,
    input  logic [31:0] PERIDATAR,
    input  logic        PERIREADY
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    bridge_state_t r_state, w_next;

    logic [CW-1:0] r_wait;
    logic [31:0]   r_sel;
    logic [11:0]   r_addr;
    logic          r_write;
    logic [2:0]    r_size;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic          w_accept, w_capture, w_mapped;
    logic [31:0]   w_dec_sel;
    logic          w_hreadyout, w_hresp, w_sel_en, w_enable;
    logic          w_unused;

    peri_addr_dec #(
        .BASE_ADDR(BASE_ADDR)
    ) u_dec (
        .i_haddr  (HADDR),
        .o_mapped (w_mapped),
        .o_perisel(w_dec_sel)
    );

    assign w_accept = HSEL & HREADY & HTRANS[1];
    // Transfer size is registered for completeness; no peripheral consumes it yet.
    assign w_unused = ^{HTRANS[0], r_size};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Acceptance is honoured in any state that completes a data phase (IDLE, ERR2),
    // so a pipelined address goes straight to SETUP/ERR1 with no idle gap.
    always_comb begin
        w_next      = r_state;
        w_hreadyout = 1'b0;
        w_hresp     = 1'b0;
        w_sel_en    = 1'b0;
        w_enable    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_hreadyout = 1'b1;
                w_hresp     = (r_state == ST_ERR2);
                w_capture   = w_accept;
                if (w_accept) w_next = w_mapped ? ST_SETUP : ST_ERR1;
                else          w_next = ST_IDLE;
            end
            ST_SETUP: begin
                w_sel_en = 1'b1;
                w_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_sel_en = 1'b1;
                w_enable = 1'b1;
                if (PERIREADY)                w_next = ST_IDLE;
                else if (r_wait == WAIT_LAST) w_next = ST_ERR1;
            end
            ST_ERR1: begin
                w_hresp = 1'b1;
                w_next  = ST_ERR2;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait <= '0;
        end else if (r_state == ST_ACCESS && !PERIREADY) begin
            r_wait <= r_wait + CW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sel   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_sel   <= w_dec_sel;
                r_addr  <= HADDR[11:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
            if (r_state == ST_SETUP && r_write) r_wdata <= HWDATA;
            if (r_state == ST_ACCESS && PERIREADY && !r_write) r_rdata <= PERIDATAR;
        end
    end

    assign HREADYOUT  = w_hreadyout;
    assign HRESP      = w_hresp;
    assign HRDATA     = r_rdata;
    assign PERISEL    = w_sel_en ? r_sel : '0;
    assign PERIADDR   = r_addr;
    assign PERIWRITE  = r_write;
    assign PERIWDATA  = r_wdata;
    assign PERIENABLE = w_enable;

endmodule

// File: tb/tb_peri_ahb_bridge.sv
// Bench for peri_ahb_bridge: table of single transfers checked through a
// scoreboard, plus pipelined, ignored-phase and mid-access reset sequences.
module tb_peri_ahb_bridge;
    import peri_ahb_bridge_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL, use_to, HWRITE, PERIREADY;
    logic [31:0] HADDR, HWDATA, PERIDATAR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic        m_hsel, m_hreadyout, m_hresp, m_periwrite, m_perienable;
    logic [31:0] m_hrdata, m_perisel, m_periwdata;
    logic [11:0] m_periaddr;
    logic        t_hsel, t_hreadyout, t_hresp, t_periwrite, t_perienable;
    logic [31:0] t_hrdata, t_perisel, t_periwdata;
    logic [11:0] t_periaddr;

    logic        v_hreadyout, v_hresp, v_perienable;
    logic [31:0] v_hrdata, v_perisel, v_periwdata;
    logic [11:0] v_periaddr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 HCLK = ~HCLK;

    // Each DUT is the only slave on its own bus, so its HREADYOUT is its HREADY.
    assign m_hsel = HSEL & ~use_to;
    assign t_hsel = HSEL & use_to;

    peri_ahb_bridge u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(m_hsel), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(m_hreadyout),
        .HREADYOUT(m_hreadyout), .HRDATA(m_hrdata), .HRESP(m_hresp),
        .PERISEL(m_perisel), .PERIADDR(m_periaddr), .PERIWRITE(m_periwrite),
        .PERIWDATA(m_periwdata), .PERIENABLE(m_perienable),
        .PERIDATAR(PERIDATAR), .PERIREADY(PERIREADY)
    );

    peri_ahb_bridge #(.TIMEOUT(4)) u_dut_to (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(t_hsel), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(t_hreadyout),
        .HREADYOUT(t_hreadyout), .HRDATA(t_hrdata), .HRESP(t_hresp),
        .PERISEL(t_perisel), .PERIADDR(t_periaddr), .PERIWRITE(t_periwrite),
        .PERIWDATA(t_periwdata), .PERIENABLE(t_perienable),
        .PERIDATAR(PERIDATAR), .PERIREADY(PERIREADY)
    );

    assign v_hreadyout  = use_to ? t_hreadyout  : m_hreadyout;
    assign v_hresp      = use_to ? t_hresp      : m_hresp;
    assign v_perienable = use_to ? t_perienable : m_perienable;
    assign v_hrdata     = use_to ? t_hrdata     : m_hrdata;
    assign v_perisel    = use_to ? t_perisel    : m_perisel;
    assign v_periwdata  = use_to ? t_periwdata  : m_periwdata;
    assign v_periaddr   = use_to ? t_periaddr   : m_periaddr;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int unsigned waits;
        logic        use_to;
        logic [31:0] e_sel;
        logic [11:0] e_paddr;
        logic        e_resp;
        int unsigned e_low;
        int unsigned e_en;
    } vec_t;

    typedef struct {
        logic [31:0] sel;
        logic [11:0] paddr;
        logic        resp;
        int unsigned low;
        int unsigned en;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rd[2];
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hreadyout"}, 32'(m_hreadyout), 32'd1);
        chk({tag, "_hresp"}, 32'(m_hresp), 32'd0);
        chk({tag, "_hrdata"}, m_hrdata, 32'd0);
        chk({tag, "_perisel"}, m_perisel, 32'd0);
        chk({tag, "_periaddr"}, 32'(m_periaddr), 32'd0);
        chk({tag, "_periwrite"}, 32'(m_periwrite), 32'd0);
        chk({tag, "_periwdata"}, m_periwdata, 32'd0);
        chk({tag, "_perienable"}, 32'(m_perienable), 32'd0);
    endtask

    task automatic run_xfer(input int idx, input vec_t v);
        exp_t        e;
        int unsigned low, en, respc;
        logic [31:0] sel_seen, wd_seen;
        logic [11:0] pa_seen;
        logic        done;
        string       t;
        t = $sformatf("v%0d", idx);
        @(negedge HCLK);
        use_to = v.use_to; HSEL = 1'b1; HADDR = v.addr; HTRANS = v.trans;
        HWRITE = v.wr; HSIZE = 3'b010; PERIREADY = 1'b0;
        e.sel = v.e_sel; e.paddr = v.e_paddr; e.resp = v.e_resp; e.low = v.e_low;
        e.en = v.e_en; e.wr = v.wr; e.wdata = v.wdata;
        e.rdata = (!v.wr && !v.e_resp) ? v.prdata : last_rd[v.use_to];
        last_rd[v.use_to] = e.rdata;
        sb.push_back(e);
        low = 0; en = 0; respc = 0; sel_seen = '0; pa_seen = '0; wd_seen = '0; done = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge HCLK);
            if (c == 1) begin HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWDATA = v.wdata; end
            if (c == 2) HWDATA = ~v.wdata;
            if (v_hresp) respc++;
            if (v_hreadyout) begin
                done = 1'b1;
                break;
            end
            low++;
            if (v_perisel != 0 && sel_seen == 0) begin sel_seen = v_perisel; pa_seen = v_periaddr; end
            if (v_perienable) begin
                en++;
                wd_seen   = v_periwdata;
                PERIREADY = (en > v.waits);
                PERIDATAR = PERIREADY ? v.prdata : (32'hBAD0_0000 + en);
            end else begin
                PERIREADY = 1'b0;
            end
        end
        n_tests++;
        if (!done || sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_complete: got no completion expected HREADYOUT=1", t);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({t, "_sel"}, sel_seen, e.sel);
        chk({t, "_paddr"}, 32'(pa_seen), 32'(e.paddr));
        chk({t, "_hresp"}, 32'(v_hresp), 32'(e.resp));
        chk({t, "_resp_cycles"}, respc, e.resp ? 32'd2 : 32'd0);
        chk({t, "_wait_cycles"}, low, e.low);
        chk({t, "_enable_cycles"}, en, e.en);
        chk({t, "_hrdata"}, v_hrdata, e.rdata);
        chk({t, "_sel_off"}, v_perisel, 32'd0);
        chk({t, "_enable_off"}, 32'(v_perienable), 32'd0);
        if (e.wr) chk({t, "_wdata"}, wd_seen, e.wdata);
        PERIREADY = 1'b0;
    endtask

    initial begin
        logic        b_rdy[6], b_en[6];
        logic [31:0] b_sel[6];
        exp_t        e;

        HSEL = 1'b0; use_to = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0; PERIDATAR = '0; PERIREADY = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;

        //          addr          trans          wr    wdata          prdata        wt    to    sel           paddr   rsp   low en
        vecs[0] = '{32'h4000_2010, HTRANS_NONSEQ, 1'b0, 32'h0,         32'hDEAD_BEEF, 0,    1'b0, 32'h0000_0008, 12'h010, 1'b0, 2, 1};
        vecs[1] = '{32'h4000_7004, HTRANS_NONSEQ, 1'b1, 32'h1234_5678, 32'h0,         4,    1'b0, 32'h0000_0100, 12'h004, 1'b0, 6, 5};
        vecs[2] = '{32'h5000_0000, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h0,         0,    1'b0, 32'h0,         12'h000, 1'b1, 1, 0};
        vecs[3] = '{32'h4000_5FFC, HTRANS_SEQ,    1'b0, 32'h0,         32'hA5A5_0F0F, 2,    1'b0, 32'h0000_0040, 12'hFFC, 1'b0, 4, 3};
        vecs[4] = '{32'h4000_0000, HTRANS_NONSEQ, 1'b1, 32'hCAFE_F00D, 32'h0,         0,    1'b0, 32'h0000_0002, 12'h000, 1'b0, 2, 1};
        vecs[5] = '{32'h4000_8000, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h0,         0,    1'b0, 32'h0,         12'h000, 1'b1, 1, 0};
        vecs[6] = '{32'h3FFF_FFFC, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h0,         0,    1'b0, 32'h0,         12'h000, 1'b1, 1, 0};
        vecs[7] = '{32'h4000_3ABC, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h0BAD_CAFE, 1,    1'b0, 32'h0000_0010, 12'hABC, 1'b0, 3, 2};
        vecs[8] = '{32'h4000_0100, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h0,         1000, 1'b1, 32'h0000_0002, 12'h100, 1'b1, 6, 4};
        vecs[9] = '{32'h4000_1004, HTRANS_NONSEQ, 1'b0, 32'h0,         32'h7777_1234, 3,    1'b1, 32'h0000_0004, 12'h004, 1'b0, 5, 4};

        #2;
        chk_reset("rst");
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < 10; i++) run_xfer(i, vecs[i]);

        // Address phases without HTRANS[1] or without HSEL must be ignored.
        use_to = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            HSEL = (k == 0); HTRANS = (k == 0) ? HTRANS_BUSY : HTRANS_NONSEQ; HADDR = 32'h4000_2000;
            for (int c = 0; c < 2; c++) begin
                @(negedge HCLK);
                chk($sformatf("ign%0d_hreadyout", k), 32'(m_hreadyout), 32'd1);
                chk($sformatf("ign%0d_perisel", k), m_perisel, 32'd0);
            end
        end
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;

        // Pipelined reads to peripherals 0 then 1; second address held while HREADY is low.
        b_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        b_en  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b_sel = '{32'h2, 32'h2, 32'h0, 32'h4, 32'h4, 32'h0};
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = 32'h4000_0040; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
        PERIREADY = 1'b1; PERIDATAR = 32'h1111_0000;
        e = '{sel: 32'h2, paddr: 12'h040, resp: 1'b0, low: 2, en: 1, wr: 1'b0, wdata: 32'h0, rdata: 32'h1111_0000};
        sb.push_back(e);
        e.rdata = 32'h2222_0000; e.sel = 32'h4;
        sb.push_back(e);
        for (int c = 1; c <= 6; c++) begin
            @(negedge HCLK);
            chk($sformatf("b2b_c%0d_hreadyout", c), 32'(m_hreadyout), 32'(b_rdy[c-1]));
            chk($sformatf("b2b_c%0d_perisel", c), m_perisel, b_sel[c-1]);
            chk($sformatf("b2b_c%0d_perienable", c), 32'(m_perienable), 32'(b_en[c-1]));
            if (m_hreadyout && sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("b2b_c%0d_hrdata", c), m_hrdata, e.rdata);
            end
            if (c == 1) HADDR = 32'h4000_1040;
            if (c == 4) begin
                HSEL = 1'b0; HTRANS = HTRANS_IDLE; PERIDATAR = 32'h2222_0000;
                chk("b2b_c4_periaddr", 32'(m_periaddr), 32'h040);
            end
        end
        last_rd[0] = 32'h2222_0000;

        // Reset while the peripheral is stalling in ACCESS.
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = 32'h4000_6008; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; PERIREADY = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        @(negedge HCLK);
        chk("rstmid_in_access", 32'(m_perienable), 32'd1);
        #2 HRESETn = 1'b0;
        #1 chk_reset("rstmid");
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_xfer(10, '{32'h4000_6008, HTRANS_NONSEQ, 1'b0, 32'h0, 32'h6666_8888, 0,
                       1'b0, 32'h0000_0080, 12'h008, 1'b0, 2, 1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
